wave_capture: RTL
=================

# wave_capture

Downstream consumer of `waveform_gen`. It selects one of the four 12-bit DDS outputs (sin/cos/squ/saw) and decimates it with a programmable divider. Samples go into a small FIFO that is drained over a valid/ready stream toward the Nios/Qsys side. Overflow is flagged, never blocking: the DDS runs freely and cannot be back-pressured.

## Interface

Parameters:
- `DATA_W`, 12: sample width, matches `waveform_gen` outputs.
- `DEPTH`, 16: FIFO entries; must be a power of 2.
- `DIV_W`, 16: divider width.

Ports:
- `clk`  in  1: single clock, shared with `waveform_gen`.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: pulse; enters/restarts capture.
- `stop`  in  1: pulse; ends capture.
- `wave_sel`  in  2: 0=sin, 1=cos, 2=squ, 3=saw.
- `div`  in  DIV_W: a sample is taken every `div`+1 cycles.
- `sin_in`, `cos_in`, `squ_in`, `saw_in`  in  DATA_W each: signed DDS outputs.
- `out_data`  out  DATA_W: FIFO head sample.
- `out_valid`  out  1: FIFO non-empty.
- `out_ready`  in  1: consumer accepts head.
- `fill`  out  log2(DEPTH)+1: current occupancy.
- `busy`  out  1: high in RUN.
- `overflow`  out  1: sticky, set when a sample was dropped.
- `clr_ovf`  in  1: clears `overflow`.

## Operation

- FSM has two states.
  - IDLE: divider held at 0; no samples taken.
  - RUN: divider counts 0..`div`, then wraps to 0.
- Transitions:
  - `start` in IDLE goes to RUN.
  - `start` in RUN stays in RUN and resets the divider to 0.
  - `stop` goes to IDLE.
  - `start` and `stop` together: `stop` wins.
- Strobe is combinational: state==RUN and counter==`div`.
  - On the strobe edge, the channel selected by `wave_sel` (read that cycle) is written to the FIFO unmodified (two's complement passthrough).
  - `div`=0 gives one sample every cycle.
  - `div` may change during RUN. The compare uses the current `div`. If the counter is already > new `div`, the counter runs to the all-ones value and wraps to 0; no strobe fires until the next match.
- FIFO:
  - Circular buffer with read/write pointers one bit wider than the index; full/empty are derived from the pointers.
  - `out_data` = mem[rd_ptr] when `out_valid`=1, else 0.
  - Pop occurs when `out_valid` && `out_ready`.
- Boundary rules:
  - Push while full with no pop: sample dropped, `overflow` set, FIFO contents unchanged.
  - Push and pop in the same cycle while full: both happen, no overflow, `fill` unchanged.
  - Push and pop in the same cycle while empty: push only; `out_valid` rises next cycle.
  - `stop` does not flush the FIFO; the remaining entries still drain.
  - `clr_ovf` and an overflow event in the same cycle: set wins.
- `busy` = (state==RUN).

## Timing

- Reset values: state IDLE, divider 0, pointers 0, `fill`=0, `out_valid`=0, `out_data`=0, `busy`=0, `overflow`=0.
- `start` sampled at edge k: `busy`=1 after edge k.
  - First strobe is in cycle k+`div`+1; the write happens at that edge.
  - `out_valid`=1 after edge k+`div`+1.
- Write-to-valid latency is 1 edge. `fill`, `out_valid` and `overflow` are all registered.
- `stop` at edge m:
  - `busy`=0 after edge m.
  - A strobe coincident with `stop` in cycle m is still written.
- `reset` mid-operation: all state returns to reset values at that edge, regardless of FIFO contents or other inputs.

## Test plan

- Reset: drive `reset`=1 for 2 cycles with random inputs, then release → all outputs 0, `busy`=0, `fill`=0.
- Decimation: `div`=3, `wave_sel`=3, `saw_in` incrementing by 1 per cycle from 0, `out_ready`=1, `start` at edge k → exactly one sample every 4 cycles. Values form a ramp stepping by 4. The first `out_valid` is after edge k+4.
- Overflow: `div`=0, `out_ready`=0, run 20 cycles → `fill`=16 and `overflow`=1 from the 17th strobe. Draining afterwards returns the first 16 samples in order.
- Full with concurrent push and pop: FIFO full, `out_ready`=1, `div`=0 → `fill` stays 16 and `overflow` stays 0. `clr_ovf` pulsed without an overflow event clears `overflow`.
- Control races:
  - `start`+`stop` in the same cycle from IDLE → remains IDLE.
  - `stop` during RUN with `fill`=5 → no further writes; the 5 entries drain.
  - Switching `wave_sel` 0→1 mid-run → samples switch from `sin_in` to `cos_in` at the next strobe.
- Reset mid-run: `fill`=5, `busy`=1, assert `reset` for 1 cycle → next cycle `fill`=0, `out_valid`=0, `busy`=0, `overflow`=0.

Source files
------------

// File: rtl/wave_capture.sv
// wave_capture: decimates one selected DDS channel into a small FIFO drained over valid/ready.
// Overflow drops the new sample and sets a sticky flag; the DDS side is never stalled.
module wave_capture #(
    parameter int DATA_W = 12,
    parameter int DEPTH = 16,
    parameter int DIV_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic [1:0]               wave_sel,
    input  logic [DIV_W-1:0]         div,
    input  logic [DATA_W-1:0]        sin_in,
    input  logic [DATA_W-1:0]        cos_in,
    input  logic [DATA_W-1:0]        squ_in,
    input  logic [DATA_W-1:0]        saw_in,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     busy,
    output logic                     overflow,
    input  logic                     clr_ovf
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state, state_nx;
    logic [DIV_W-1:0] cnt;
    logic [AW:0] wr_ptr, rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] sample;
    logic strobe, full, pop, push;

    always_ff @(posedge clk)
        state <= reset ? IDLE : state_nx;

    always_comb
        state_nx = stop ? IDLE : start ? RUN : state;

    always_comb begin
        busy = state == RUN;
        strobe = busy && cnt == div;
    end

    // A shrunken div below the counter lets it run through all-ones before matching again.
    always_ff @(posedge clk)
        cnt <= (reset || !busy || start || stop || strobe) ? '0 : cnt + 1'b1;

    always_comb begin
        sample = wave_sel == 2'd0 ? sin_in :
                 wave_sel == 2'd1 ? cos_in :
                 wave_sel == 2'd2 ? squ_in : saw_in;
        full = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
        out_valid = wr_ptr != rd_ptr;
        pop = out_valid && out_ready;
        push = strobe && (!full || pop);
        fill = wr_ptr - rd_ptr;
        out_data = out_valid ? mem[rd_ptr[AW-1:0]] : '0;
    end

    always_ff @(posedge clk)
        if (push)
            mem[wr_ptr[AW-1:0]] <= sample;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            overflow <= (strobe && full && !pop) || (overflow && !clr_ovf);
        end
    end
endmodule
